// File: rtl/ffe_sample_sequencer_if.sv
// Sample handshake and tap-read bus between the FFE sample source, the sequencer and the datapath.
interface ffe_sample_sequencer_if #(
  parameter int IN_OUT_BUS_WIDTH = 12,
  parameter int DEPTH            = 4,
  parameter int ADDR_SIZE        = $clog2(DEPTH)
);
  logic                               in_valid;
  logic signed [IN_OUT_BUS_WIDTH-1:0] in_data;
  logic                               in_ready;
  logic        [ADDR_SIZE-1:0]        rd_addr;
  logic signed [IN_OUT_BUS_WIDTH-1:0] rd_data;
  logic                               str_out_n_rst_add_reg;
  logic                               busy;

  modport master (
    output in_valid, in_data,
    input  in_ready, rd_addr, rd_data, str_out_n_rst_add_reg, busy
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, rd_addr, rd_data, str_out_n_rst_add_reg, busy
  );
endinterface

// File: rtl/ffe_sample_sequencer.sv
// FFE sample delay line and tap walker; presents x[n-k] for k=0..DEPTH-1 per accepted sample.
// Optional one-entry input skid register enabled by defining FFE_SKID_BUF_EN.
module ffe_sample_sequencer #(
  parameter int IN_OUT_BUS_WIDTH = 12,
  parameter int DEPTH            = 4,
  parameter int ADDR_SIZE        = $clog2(DEPTH)
) (
  input  logic                   ffe_clk,
  input  logic                   rst,
  ffe_sample_sequencer_if.slave  bus
);

  typedef enum logic {IDLE, WALK} state_t;

  localparam logic [ADDR_SIZE-1:0] LAST_TAP = ADDR_SIZE'(DEPTH - 1);

  state_t                             state, state_next;
  logic        [ADDR_SIZE-1:0]        tap, tap_next;
  logic        [ADDR_SIZE-1:0]        wr_ptr, cur, rd_idx, rd_addr;
  logic signed [IN_OUT_BUS_WIDTH-1:0] dly_buf [DEPTH];
  logic signed [IN_OUT_BUS_WIDTH-1:0] start_data;
  logic                               last_tap, accept, start, in_ready;

  assign last_tap = (state == WALK) && (tap == LAST_TAP);
  assign accept   = bus.in_valid && in_ready;

`ifdef FFE_SKID_BUF_EN
  logic                               skid_full;
  logic signed [IN_OUT_BUS_WIDTH-1:0] skid_data;

  assign in_ready = !skid_full;
  // A held skid sample launches the next walk; it is always older than any direct accept.
  assign start      = ((state == IDLE) && accept) || (last_tap && (skid_full || accept));
  assign start_data = skid_full ? skid_data : bus.in_data;

  always_ff @(posedge ffe_clk or negedge rst) begin
    if (!rst) begin
      skid_full <= 1'b0;
      skid_data <= '0;
    end else if (last_tap && skid_full) begin
      skid_full <= 1'b0;
    end else if (accept && (state == WALK) && !last_tap) begin
      skid_full <= 1'b1;
      skid_data <= bus.in_data;
    end
  end
`else
  assign in_ready   = (state == IDLE) || last_tap;
  assign start      = accept;
  assign start_data = bus.in_data;
`endif

  always_ff @(posedge ffe_clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      tap   <= '0;
    end else begin
      state <= state_next;
      tap   <= tap_next;
    end
  end

  always_comb begin
    state_next = state;
    tap_next   = tap;
    case (state)
      IDLE: begin
        tap_next = '0;
        if (start) state_next = WALK;
      end
      WALK: begin
        if (tap == LAST_TAP) begin
          tap_next   = '0;
          state_next = start ? WALK : IDLE;
        end else begin
          tap_next = tap + ADDR_SIZE'(1);
        end
      end
      default: begin
        state_next = IDLE;
        tap_next   = '0;
      end
    endcase
  end

  // Writing the oldest slot on a last-tap start is safe: that slot was read at k=DEPTH-1 via the old cur.
  always_ff @(posedge ffe_clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) dly_buf[i] <= '0;
      wr_ptr <= '0;
      cur    <= '0;
    end else if (start) begin
      dly_buf[wr_ptr] <= start_data;
      cur             <= wr_ptr;
      wr_ptr          <= wr_ptr + ADDR_SIZE'(1);
    end
  end

  assign rd_addr = (state == WALK) ? tap : '0;
  assign rd_idx  = cur - rd_addr;

  assign bus.in_ready              = in_ready;
  assign bus.busy                  = (state == WALK);
  assign bus.rd_addr               = rd_addr;
  assign bus.rd_data               = dly_buf[rd_idx];
  assign bus.str_out_n_rst_add_reg = last_tap;

endmodule

// File: tb/tb_ffe_sample_sequencer.sv
// Directed self-checking bench for ffe_sample_sequencer (DEPTH=4, 12-bit samples).
module tb_ffe_sample_sequencer;

  logic ffe_clk = 1'b0;
  logic rst     = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  ffe_sample_sequencer_if #(.IN_OUT_BUS_WIDTH(12), .DEPTH(4)) bus ();

  ffe_sample_sequencer #(.IN_OUT_BUS_WIDTH(12), .DEPTH(4)) dut (
    .ffe_clk (ffe_clk),
    .rst     (rst),
    .bus     (bus.slave)
  );

  always #5 ffe_clk = ~ffe_clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ffe_clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst = 1'b0;
    repeat (2) @(posedge ffe_clk);
    @(negedge ffe_clk);
    rst = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, int'(bus.in_ready), 1);
    check({tag, "_busy"},  int'(bus.busy), 0);
    check({tag, "_addr"},  int'(bus.rd_addr), 0);
    check({tag, "_strb"},  int'(bus.str_out_n_rst_add_reg), 0);
  endtask

  // Starts in the tap-0 cycle and leaves the bench in the tap-3 cycle.
  task automatic check_walk(input string tag, input int e0, input int e1, input int e2, input int e3);
    int exp_d [4];
    exp_d = '{e0, e1, e2, e3};
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      check($sformatf("%s_k%0d_addr", tag, k), int'(bus.rd_addr), k);
      check($sformatf("%s_k%0d_data", tag, k), int'(bus.rd_data), exp_d[k]);
      check($sformatf("%s_k%0d_strb", tag, k), int'(bus.str_out_n_rst_add_reg), (k == 3) ? 1 : 0);
      check($sformatf("%s_k%0d_busy", tag, k), int'(bus.busy), 1);
    end
  endtask

  initial begin
    do_reset();
    #1;
    check_idle("rst");
    check("rst_data", int'(bus.rd_data), 0);

    // Single sample after reset
    bus.in_valid = 1'b1;
    bus.in_data  = 12'sd2047;
    tick();
    bus.in_valid = 1'b0;
    check_walk("single", 2047, 0, 0, 0);
    tick();
    check_idle("single_end");

    // Back-to-back stream, next sample offered in the last-tap cycle
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = 12'sd100;
    tick();
    bus.in_valid = 1'b0;
    check_walk("s1", 100, 0, 0, 0);
    check("s1_ready", int'(bus.in_ready), 1);
    bus.in_valid = 1'b1; bus.in_data = 12'sd200; tick(); bus.in_valid = 1'b0;
    check_walk("s2", 200, 100, 0, 0);
    bus.in_valid = 1'b1; bus.in_data = 12'sd300; tick(); bus.in_valid = 1'b0;
    check_walk("s3", 300, 200, 100, 0);
    bus.in_valid = 1'b1; bus.in_data = 12'sd400; tick(); bus.in_valid = 1'b0;
    check_walk("s4", 400, 300, 200, 100);
    bus.in_valid = 1'b1; bus.in_data = 12'sd500; tick(); bus.in_valid = 1'b0;
    check_walk("s5", 500, 400, 300, 200);
    tick();
    check_idle("s_end");

`ifndef FFE_SKID_BUF_EN
    // Mid-walk offer is held off until the last tap
    do_reset();
    bus.in_valid = 1'b1; bus.in_data = 12'sd11; tick();
    bus.in_data = 12'sd22;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      check($sformatf("hold_k%0d_ready", k), int'(bus.in_ready), (k == 3) ? 1 : 0);
    end
    tick();
    bus.in_valid = 1'b0;
    check_walk("hold", 22, 11, 0, 0);
    tick();
    check_idle("hold_end");
`else
    // Skid: sample offered at k=0 is captured and launched after the strobe
    do_reset();
    bus.in_valid = 1'b1; bus.in_data = 12'sd10; tick();
    bus.in_data = 12'sd55;
    check("skid_k0_ready", int'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    check("skid_k1_ready", int'(bus.in_ready), 0);
    check("skid_k1_addr", int'(bus.rd_addr), 1);
    tick();
    tick();
    check("skid_k3_strb", int'(bus.str_out_n_rst_add_reg), 1);
    check("skid_k3_ready", int'(bus.in_ready), 0);
    tick();
    check_walk("skid", 55, 10, 0, 0);
    tick();
    check_idle("skid_end");
`endif

    // Asynchronous reset at k=2
    do_reset();
    bus.in_valid = 1'b1; bus.in_data = 12'sd3; tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    check("abort_k2_addr", int'(bus.rd_addr), 2);
    #2 rst = 1'b0;
    #1;
    check_idle("abort");
    check("abort_data", int'(bus.rd_data), 0);
    @(posedge ffe_clk);
    @(negedge ffe_clk);
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 12'sd7; tick();
    bus.in_valid = 1'b0;
    check_walk("after_abort", 7, 0, 0, 0);
    tick();
    check_idle("after_abort_end");

    // Pointer wrap: nine samples 1..9
    do_reset();
    for (int s = 1; s <= 8; s++) begin
      bus.in_valid = 1'b1; bus.in_data = 12'(s); tick();
      bus.in_valid = 1'b0;
      tick(); tick(); tick();
    end
    bus.in_valid = 1'b1; bus.in_data = 12'sd9; tick();
    bus.in_valid = 1'b0;
    check_walk("wrap", 9, 8, 7, 6);
    tick();
    check_idle("wrap_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ffe_sample_sequencer.md
# ffe_sample_sequencer

Upstream feeder for the FFE datapath. Accepts one signed input sample per valid/ready handshake and stores it in a DEPTH-entry circular delay line. It then walks the taps over DEPTH consecutive cycles, presenting tap index and delayed sample (`rd_addr`, `rd_data`) to the datapath. On the final tap it pulses `str_out_n_rst_add_reg` so the datapath emits y and clears its accumulator.

## Interface
- `IN_OUT_BUS_WIDTH`, 12, sample width (signed, Q1.11)
- `DEPTH`, 4, number of taps / delay-line entries (power of two, ≥2)
- `ADDR_SIZE`, $clog2(DEPTH), tap index width
- Clock and reset: one clock; reset is asynchronous and active-low.
- `ffe_clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous active-low reset
- `in_valid`  in  1  `in_data` holds a new sample
- `in_data`  in  IN_OUT_BUS_WIDTH  signed sample x[n]
- `in_ready`  out  1  sample accepted on an edge where `in_valid` and `in_ready` are both high
- `rd_addr`  out  ADDR_SIZE  tap index k currently presented
- `rd_data`  out  IN_OUT_BUS_WIDTH  signed x[n−k]
- `str_out_n_rst_add_reg`  out  1  high during the last-tap cycle (k = DEPTH−1)
- `busy`  out  1  tap walk in progress

## Operation
- Storage: DEPTH×IN_OUT_BUS_WIDTH register array plus write pointer `wr_ptr` (ADDR_SIZE bits; wraps DEPTH−1→0 naturally).
- Accept: the sample is written to `buf[wr_ptr]`. The pointer of the newest sample, `cur`, latches `wr_ptr`, and `wr_ptr` increments.
- `rd_data = buf[(cur − rd_addr) mod DEPTH]`: a combinational read of registered storage. Modular subtraction is plain ADDR_SIZE-bit wrap.
- FSM:
  - IDLE: `busy`=0, `rd_addr`=0, `str_out_n_rst_add_reg`=0. On accept → WALK with tap=0.
  - WALK: `busy`=1. `rd_addr`=tap and tap increments each cycle.
  - When tap=DEPTH−1, `str_out_n_rst_add_reg`=1. The next state is WALK with tap=0 if a sample is accepted on that edge; otherwise IDLE.
- `in_ready` = IDLE, or (WALK and tap=DEPTH−1). Back-to-back throughput is one sample per DEPTH cycles with no bubble.
- `in_valid` is ignored while `in_ready`=0. The source must hold the sample.
- Delay-line history before DEPTH samples have been accepted reads as zero, because reset clears the array.

## Timing
- Reset (async assert, synchronous release): array = 0, `wr_ptr`=0, `cur`=0, state IDLE.
- Output reset values: `in_ready`=1, `busy`=0, `rd_addr`=0, `rd_data`=0, `str_out_n_rst_add_reg`=0.
- Latency: the sample accepted at edge E appears as tap 0 in the cycle after E. `str_out_n_rst_add_reg` is high in cycle E+DEPTH, and the datapath's y is valid combinationally in that same cycle.
- The write at an accept edge on the last tap does not disturb the current last-tap read. The read uses the old `cur`, and `buf[wr_ptr]` is the oldest entry, already consumed at k=DEPTH−1.
- Reset mid-walk aborts immediately. No strobe is emitted and the history is lost.
- `str_out_n_rst_add_reg` is exactly one cycle wide per accepted sample and is never asserted in IDLE.

## Configuration
- `FFE_SKID_BUF_EN` defined: adds a one-entry skid register.
  - `in_ready` = !skid_full.
  - A sample accepted during WALK (tap<DEPTH−1) is held in the skid register and started at the last-tap edge, as if accepted there.
  - A skid is drained before any new direct accept.
  - Reset clears `skid_full`.
- Undefined: no skid register. `in_ready` follows the FSM rule above.

## Test plan
- Reset then sample 2047 → `rd_addr` 0,1,2,3 with `rd_data` 2047,0,0,0; strobe only in the k=3 cycle; `busy` drops the next cycle.
- Continuous `in_valid`, samples 100,200,300,400,500 → second walk `rd_data` 200,100,0,0; fifth walk 500,400,300,200; no idle cycles and one strobe per sample.
- `in_valid` asserted mid-walk (no skid) → `in_ready`=0 until k=3, accept at that edge, the next walk starts immediately.
- `rst` pulled low at k=2 → all outputs go to their reset values asynchronously; the next sample 7 walks as 7,0,0,0.
- Wrap: 9 samples 1..9 → ninth walk `rd_data` 9,8,7,6 after `wr_ptr` has wrapped twice.
- `FFE_SKID_BUF_EN`: sample 55 at k=0 is accepted (`in_ready`=1 then 0). Its walk starts right after the strobe and shows 55 as tap 0.
